// File: rtl/mems_sampler.sv
// mems_sampler: periodically samples the X/Y/Z axes of a MEMS sensor through
// a SPI peripheral reached over a master bus, and exposes the results and
// status over a CPU slave bus.
// Optional feature: define MEMS_SAMPLER_TIMEOUT_EN to bound the wait for the
// end of an SPI transfer with a 16-bit timeout counter.
module mems_sampler #(
  parameter int unsigned LGPERIOD = 24
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  // CPU slave bus
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  // master bus to the MEMS SPI peripheral
  output logic        o_mw_cyc,
  output logic        o_mw_stb,
  output logic        o_mw_we,
  output logic [7:0]  o_mw_addr,
  output logic [31:0] o_mw_data,
  input  logic        i_mw_ack,
  input  logic        i_mw_stall,
  input  logic [31:0] i_mw_data,
  input  logic        i_mems_done,
  output logic        o_int
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_CMD,
    S_WAIT_DONE,
    S_READ,
    S_COMMIT
  } state_t;

  localparam logic [7:0] ADDR_X = 8'hE8;
  localparam logic [7:0] ADDR_Y = 8'hEA;
  localparam logic [7:0] ADDR_Z = 8'hEC;

  state_t              state;
  logic [1:0]          axis;
  logic [15:0]         shadow_x, shadow_y, shadow_z;
  logic [15:0]         reg_x, reg_y, reg_z;
  logic [7:0]          sample_cnt;
  logic                sts_new, sts_overrun, sts_timeout;
  logic                ctrl_enable;
  logic [LGPERIOD-1:0] ctrl_period, period_cnt;
  logic [LGPERIOD-1:0] wr_period, wr_reload, cur_reload;
  logic                busy, tick, ctrl_wr, status_wr, mw_done;
  logic [7:0]          axis_addr, next_axis_addr;
  logic [31:0]         ctrl_rd, status_rd, rd_mux;
  logic                unused_inputs;

`ifdef MEMS_SAMPLER_TIMEOUT_EN
  logic [15:0]         wait_cnt;
`else
  assign sts_timeout = 1'b0;
`endif

  assign o_wb_stall    = 1'b0;
  assign o_mw_data     = '0;
  assign unused_inputs = &{1'b0, i_wb_data[7:3], i_mw_data[30:16]};

  // Bus decode, tick generation and per-axis address selection
  always_comb begin
    busy      = (state != S_IDLE);
    tick      = ctrl_enable && (period_cnt == '0);
    ctrl_wr   = i_wb_cyc && i_wb_stb && i_wb_we && (i_wb_addr == 3'd0);
    status_wr = i_wb_cyc && i_wb_stb && i_wb_we && (i_wb_addr == 3'd1);
    mw_done   = o_mw_cyc && i_mw_ack;
    wr_period = i_wb_data[8 +: LGPERIOD];
    // period 0 and period 1 both give a tick every cycle
    wr_reload  = (wr_period == '0) ? '0 : wr_period - 1'b1;
    cur_reload = (ctrl_period == '0) ? '0 : ctrl_period - 1'b1;
    case (axis)
      2'd0:    axis_addr = ADDR_X;
      2'd1:    axis_addr = ADDR_Y;
      default: axis_addr = ADDR_Z;
    endcase
    case (axis)
      2'd0:    next_axis_addr = ADDR_Y;
      default: next_axis_addr = ADDR_Z;
    endcase
  end

  // Register read mux
  always_comb begin
    ctrl_rd                 = '0;
    ctrl_rd[8 +: LGPERIOD]  = ctrl_period;
    ctrl_rd[0]              = ctrl_enable;
    status_rd = {16'h0000, sample_cnt, 4'h0, sts_timeout, sts_overrun, sts_new, busy};
    case (i_wb_addr)
      3'd0:    rd_mux = ctrl_rd;
      3'd1:    rd_mux = status_rd;
      3'd2:    rd_mux = {16'h0000, reg_x};
      3'd3:    rd_mux = {16'h0000, reg_y};
      3'd4:    rd_mux = {16'h0000, reg_z};
      default: rd_mux = '0;
    endcase
  end

  // Slave ack follows strobe by one cycle, with read data alongside
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= i_wb_stb;
      if (i_wb_stb)
        o_wb_data <= rd_mux;
    end
  end

  // CTRL register and sample-period counter
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ctrl_period <= '0;
      ctrl_enable <= 1'b0;
      period_cnt  <= '0;
    end else if (ctrl_wr) begin
      ctrl_period <= wr_period;
      ctrl_enable <= i_wb_data[0];
      period_cnt  <= wr_reload;
    end else if (tick) begin
      period_cnt  <= cur_reload;
    end else if (period_cnt != '0) begin
      period_cnt  <= period_cnt - 1'b1;
    end
  end

  // Sampling sequencer, master bus requests, results and status flags
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      axis        <= '0;
      o_mw_cyc    <= 1'b0;
      o_mw_stb    <= 1'b0;
      o_mw_we     <= 1'b0;
      o_mw_addr   <= '0;
      shadow_x    <= '0;
      shadow_y    <= '0;
      shadow_z    <= '0;
      reg_x       <= '0;
      reg_y       <= '0;
      reg_z       <= '0;
      sample_cnt  <= '0;
      sts_new     <= 1'b0;
      sts_overrun <= 1'b0;
      o_int       <= 1'b0;
`ifdef MEMS_SAMPLER_TIMEOUT_EN
      wait_cnt    <= '0;
      sts_timeout <= 1'b0;
`endif
    end else begin
      o_int <= 1'b0;

      // CPU clears come first so that set events below take priority
      if (status_wr) begin
        if (i_wb_data[1]) sts_new     <= 1'b0;
        if (i_wb_data[2]) sts_overrun <= 1'b0;
`ifdef MEMS_SAMPLER_TIMEOUT_EN
        if (i_wb_data[3]) sts_timeout <= 1'b0;
`endif
      end
      if (tick && busy)
        sts_overrun <= 1'b1;

      // strobe retires once the peripheral accepts it; cycle waits for ack
      if (o_mw_stb && !i_mw_stall)
        o_mw_stb <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tick) begin
            state     <= S_POLL;
            axis      <= 2'd0;
            o_mw_cyc  <= 1'b1;
            o_mw_stb  <= 1'b1;
            o_mw_we   <= 1'b0;
            o_mw_addr <= ADDR_X;
          end
        end

        S_POLL: begin
          if (mw_done) begin
            o_mw_cyc  <= 1'b1;
            o_mw_stb  <= 1'b1;
            o_mw_addr <= axis_addr;
            if (i_mw_data[31]) begin
              o_mw_we <= 1'b0;
            end else begin
              o_mw_we <= 1'b1;
              state   <= S_CMD;
            end
          end
        end

        S_CMD: begin
          if (mw_done) begin
            state    <= S_WAIT_DONE;
            o_mw_cyc <= 1'b0;
            o_mw_stb <= 1'b0;
            o_mw_we  <= 1'b0;
`ifdef MEMS_SAMPLER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        S_WAIT_DONE: begin
          if (i_mems_done) begin
            state     <= S_READ;
            o_mw_cyc  <= 1'b1;
            o_mw_stb  <= 1'b1;
            o_mw_we   <= 1'b0;
            o_mw_addr <= axis_addr;
`ifdef MEMS_SAMPLER_TIMEOUT_EN
          end else if (wait_cnt == 16'hFFFF) begin
            sts_timeout <= 1'b1;
            state       <= S_IDLE;
            o_mw_cyc    <= 1'b0;
            o_mw_stb    <= 1'b0;
            o_mw_we     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end

        S_READ: begin
          if (mw_done) begin
            case (axis)
              2'd0:    shadow_x <= i_mw_data[15:0];
              2'd1:    shadow_y <= i_mw_data[15:0];
              default: shadow_z <= i_mw_data[15:0];
            endcase
            o_mw_cyc <= 1'b0;
            o_mw_stb <= 1'b0;
            o_mw_we  <= 1'b0;
            if (axis == 2'd2) begin
              state <= S_COMMIT;
            end else begin
              state     <= S_POLL;
              axis      <= axis + 2'd1;
              o_mw_cyc  <= 1'b1;
              o_mw_stb  <= 1'b1;
              o_mw_addr <= next_axis_addr;
            end
          end
        end

        S_COMMIT: begin
          reg_x      <= shadow_x;
          reg_y      <= shadow_y;
          reg_z      <= shadow_z;
          sts_new    <= 1'b1;
          sample_cnt <= sample_cnt + 8'd1;
          o_int      <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mems_sampler.sv
// Self-checking bench for mems_sampler: register table, a behavioural SPI
// peripheral on the master bus, and hand-written multi-cycle sequences.
module tb_mems_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        o_wb_ack, o_wb_stall;
  logic [31:0] o_wb_data;
  logic        o_mw_cyc, o_mw_stb, o_mw_we;
  logic [7:0]  o_mw_addr;
  logic [31:0] o_mw_data;
  logic        mw_ack, mw_stall, mems_done;
  logic [31:0] mw_data;
  logic        o_int;

  always #5 clk = ~clk;

  mems_sampler #(.LGPERIOD(24)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_mw_cyc(o_mw_cyc), .o_mw_stb(o_mw_stb), .o_mw_we(o_mw_we),
    .o_mw_addr(o_mw_addr), .o_mw_data(o_mw_data),
    .i_mw_ack(mw_ack), .i_mw_stall(mw_stall), .i_mw_data(mw_data),
    .i_mems_done(mems_done), .o_int(o_int)
  );

  int passed = 0;
  int total  = 0;
  logic [31:0] sb_q[$];

  // peripheral model controls and observations
  int          busy_polls, done_delay, stall_cmd, done_cnt;
  bit          hold_stall, done_never, data_phase;
  logic [15:0] axis_val [3];
  int          reads_before_write, writes_total, e8_writes, z_reads;
  int          int_cnt, stab_err, stall_seen;
  bit          first_wr_seen;
  logic [7:0]  first_wr_addr, last_wr_addr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_data = d;
    step(1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] want;
    sb_q.push_back(exp);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
    step(1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    want = sb_q.pop_front();
    if (o_wb_ack !== 1'b1) begin
      total++;
      $display("FAIL %s_ack: got %b expected 1", nm, o_wb_ack);
    end else begin
      check(nm, o_wb_data, want);
    end
  endtask

  task automatic model_clear();
    busy_polls = 0; done_delay = 5; stall_cmd = 0; hold_stall = 0; done_never = 0;
    data_phase = 0; done_cnt = -1;
    reads_before_write = 0; writes_total = 0; e8_writes = 0; z_reads = 0;
    int_cnt = 0; stab_err = 0; stall_seen = 0; first_wr_seen = 0;
    first_wr_addr = '0; last_wr_addr = '0;
  endtask

  // Behavioural SPI peripheral: acks one cycle after acceptance
  initial begin
    bit         p_stb, p_stall, p_we, e_rst;
    logic [7:0] p_addr;
    int         idx;
    p_stb = 0; p_stall = 0; p_we = 0; p_addr = '0;
    mw_ack = 0; mw_stall = 0; mw_data = '0; mems_done = 0;
    model_clear();
    forever begin
      @(posedge clk);
      e_rst = rst_n;
      #1;
      mw_ack = 0; mw_data = '0; mems_done = 0;
      if (o_int) int_cnt++;
      if (e_rst && p_stb && p_stall &&
          !(o_mw_stb && o_mw_addr == p_addr && o_mw_we == p_we))
        stab_err++;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin mems_done = 1; done_cnt = -1; end
      end
      if (p_stb && !p_stall) begin
        mw_ack = 1;
        idx = (p_addr == 8'hE8) ? 0 : (p_addr == 8'hEA) ? 1 : 2;
        if (p_we) begin
          writes_total++;
          if (!first_wr_seen) begin first_wr_seen = 1; first_wr_addr = p_addr; end
          if (p_addr == 8'hE8) e8_writes++;
          last_wr_addr = p_addr;
          data_phase = 1;
          done_cnt = done_never ? -1 : done_delay;
        end else if (data_phase) begin
          mw_data = {16'h0000, axis_val[idx]};
          data_phase = 0;
          if (idx == 2) z_reads++;
        end else begin
          if (!first_wr_seen) reads_before_write++;
          if (busy_polls > 0) begin mw_data = 32'h8000_0000; busy_polls--; end
        end
      end
      mw_stall = 0;
      if (hold_stall) mw_stall = 1;
      else if (o_mw_stb && o_mw_we && stall_cmd > 0) begin
        mw_stall = 1; stall_cmd--; stall_seen++;
      end
      p_stb = o_mw_stb; p_stall = mw_stall; p_addr = o_mw_addr; p_we = o_mw_we;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl [13];

  initial begin
    int cnt_exp;
    tbl[0]  = '{0, 3'd0, 32'h0, 32'h0,        "rst_ctrl"};
    tbl[1]  = '{0, 3'd1, 32'h0, 32'h0,        "rst_status"};
    tbl[2]  = '{0, 3'd2, 32'h0, 32'h0,        "rst_x"};
    tbl[3]  = '{0, 3'd3, 32'h0, 32'h0,        "rst_y"};
    tbl[4]  = '{0, 3'd4, 32'h0, 32'h0,        "rst_z"};
    tbl[5]  = '{1, 3'd5, 32'hFFFF_FFFF, 32'h0, "wr5"};
    tbl[6]  = '{0, 3'd5, 32'h0, 32'h0,        "rd5"};
    tbl[7]  = '{1, 3'd0, 32'h00AB_CD00, 32'h0, "wr_ctrl"};
    tbl[8]  = '{0, 3'd0, 32'h0, 32'h00AB_CD00, "rd_ctrl"};
    tbl[9]  = '{1, 3'd7, 32'h0000_0001, 32'h0, "wr7"};
    tbl[10] = '{0, 3'd7, 32'h0, 32'h0,        "rd7"};
    tbl[11] = '{1, 3'd0, 32'h0, 32'h0,        "wr_ctrl0"};
    tbl[12] = '{0, 3'd1, 32'h0, 32'h0,        "status_idle"};

    rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
    step(3);
    check("rst_mw_cyc", 32'(o_mw_cyc), 32'd0);
    check("rst_int", 32'(o_int), 32'd0);
    rst_n = 1;
    step(1);
    check("wb_stall_tie", 32'(o_wb_stall), 32'd0);
    check("mw_data_tie", o_mw_data, 32'd0);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].we) wb_write(tbl[i].addr, tbl[i].data);
      else           wb_read(tbl[i].addr, tbl[i].exp, tbl[i].nm);
    end

    // nominal sample set with three busy polls on X
    model_clear();
    axis_val[0] = 16'h0123; axis_val[1] = 16'h0456; axis_val[2] = 16'hFF00;
    busy_polls = 3;
    wb_write(3'd0, 32'h0000_6401);
    for (int k = 0; k < 300 && !o_mw_cyc; k++) step(1);
    check("seq1_start", 32'(o_mw_cyc), 32'd1);
    wb_write(3'd0, 32'h0000_6400);
    for (int k = 0; k < 2000 && int_cnt == 0; k++) step(1);
    step(300);
    check("seq1_int_once", 32'(int_cnt), 32'd1);
    check("polls_before_cmd", 32'(reads_before_write), 32'd4);
    check("first_cmd_addr", 32'(first_wr_addr), 32'h0000_00E8);
    check("seq1_writes", 32'(writes_total), 32'd3);
    wb_read(3'd2, 32'h0000_0123, "seq1_x");
    wb_read(3'd3, 32'h0000_0456, "seq1_y");
    wb_read(3'd4, 32'h0000_FF00, "seq1_z");
    wb_read(3'd1, 32'h0000_0102, "seq1_status");
    wb_write(3'd1, 32'h0000_0002);
    wb_read(3'd1, 32'h0000_0100, "new_w1c");

    // stalled CMD write, plus a clear of new coinciding with COMMIT
    model_clear();
    axis_val[0] = 16'h0AAA; axis_val[1] = 16'h0BBB; axis_val[2] = 16'h0CCC;
    stall_cmd = 5;
    wb_write(3'd0, 32'h0000_6401);
    for (int k = 0; k < 300 && !o_mw_cyc; k++) step(1);
    wb_write(3'd0, 32'h0000_6400);
    for (int k = 0; k < 2000 && z_reads == 0; k++) step(1);
    step(1);
    wb_write(3'd1, 32'h0000_0002);
    step(20);
    check("stall_cycles", 32'(stall_seen), 32'd5);
    check("stall_stable", 32'(stab_err), 32'd0);
    check("stall_e8_writes", 32'(e8_writes), 32'd1);
    check("stall_int_once", 32'(int_cnt), 32'd1);
    wb_read(3'd1, 32'h0000_0202, "commit_beats_w1c");
    wb_read(3'd2, 32'h0000_0AAA, "stall_x");
    wb_read(3'd4, 32'h0000_0CCC, "stall_z");

    // period 1 against a slow peripheral
    wb_write(3'd1, 32'h0000_0006);
    model_clear();
    axis_val[0] = 16'h1111; axis_val[1] = 16'h2222; axis_val[2] = 16'h3333;
    done_delay = 200;
    wb_write(3'd0, 32'h0000_0101);
    for (int k = 0; k < 3000 && int_cnt < 2; k++) step(1);
    wb_write(3'd0, 32'h0000_0100);
    step(1000);
    check("ovr_int_per_commit", 32'(int_cnt), 32'(z_reads));
    check("ovr_two_sets", 32'(int_cnt >= 2), 32'd1);
    cnt_exp = (2 + z_reads) & 8'hFF;
    wb_read(3'd1, 32'(cnt_exp << 8) | 32'h6, "ovr_status");
    wb_read(3'd3, 32'h0000_2222, "ovr_y");

    // reset during WAIT_DONE of Y; the late done pulse must be ignored
    model_clear();
    done_delay = 50;
    wb_write(3'd0, 32'h0000_6401);
    for (int k = 0; k < 300 && !o_mw_cyc; k++) step(1);
    wb_write(3'd0, 32'h0000_6400);
    for (int k = 0; k < 2000 && !(last_wr_addr == 8'hEA && !o_mw_cyc); k++) step(1);
    check("wd_y_reached", 32'(last_wr_addr), 32'h0000_00EA);
    rst_n = 0;
    step(1);
    rst_n = 1;
    check("rst_wd_cyc", 32'(o_mw_cyc), 32'd0);
    step(100);
    check("stale_done_cyc", 32'(o_mw_cyc), 32'd0);
    check("stale_done_int", 32'(int_cnt), 32'd0);
    wb_read(3'd1, 32'h0, "rst_wd_status");
    wb_read(3'd2, 32'h0, "rst_wd_x");
    wb_read(3'd3, 32'h0, "rst_wd_y");
    wb_read(3'd4, 32'h0, "rst_wd_z");
    wb_read(3'd0, 32'h0, "rst_wd_ctrl");

    // reset while a request is held by stall
    model_clear();
    hold_stall = 1;
    wb_write(3'd0, 32'h0000_6401);
    for (int k = 0; k < 300 && !o_mw_cyc; k++) step(1);
    step(3);
    check("held_stb", 32'(o_mw_stb), 32'd1);
    rst_n = 0;
    step(1);
    check("rst_xfer_cyc", 32'(o_mw_cyc), 32'd0);
    check("rst_xfer_stb", 32'(o_mw_stb), 32'd0);
    rst_n = 1;
    hold_stall = 0;
    step(20);
    check("rst_xfer_quiet", 32'(o_mw_cyc), 32'd0);

    // peripheral never signals done
    model_clear();
    done_never = 1;
    wb_write(3'd0, 32'h0000_6401);
    for (int k = 0; k < 300 && !o_mw_cyc; k++) step(1);
    wb_write(3'd0, 32'h0000_6400);
    for (int k = 0; k < 500 && !(writes_total >= 1 && !o_mw_cyc); k++) step(1);
    check("nodone_cmd", 32'(writes_total), 32'd1);
`ifdef MEMS_SAMPLER_TIMEOUT_EN
    step(65600);
    wb_read(3'd1, 32'h0000_0008, "timeout_status");
`else
    step(3000);
    wb_read(3'd1, 32'h0000_0001, "nodone_still_busy");
`endif
    check("nodone_no_int", 32'(int_cnt), 32'd0);
    wb_read(3'd2, 32'h0, "nodone_x");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
